calc_result_formatter: RTL
==========================

// Module: calc_result_formatter
// PURPOSE
//  Upstream feeder of the calculator UART transmit path. Takes a signed binary result,
//  converts it to decimal ASCII, packs it right-justified into a DATASIZE-bit message
//  ending in LF,CR, then drives the byte-serializer handshake (data/start, tx_idle).
//  One message per accepted value. Next value accepted only after transmission completes.
// PARAMETERS
//  DATASIZE  128  message width in bits. CHARS = DATASIZE/8 bytes; first byte sent = data[DATASIZE-1 -: 8].
//  VALUE_W   32   width of the two's-complement input value.
//  DIGITS    derived, ceil(VALUE_W*log10(2)); 10 for 32. Elaboration error unless CHARS >= DIGITS+3.
// PORTS
//  clk          in   1         system clock (100 MHz board clock)
//  reset        in   1         synchronous, active-high reset
//  value        in   VALUE_W   signed result to print
//  value_valid  in   1         value present. Accepted on the edge where value_valid & ready.
//  ready        out  1         formatter idle, can accept a value
//  data         out  DATASIZE  ASCII message to the byte serializer
//  start        out  1         request to the serializer to send data
//  tx_idle      in   1         serializer idle (its state == 0); low while sending
// BEHAVIOUR
//  Clock and reset: one clock, clk. reset is synchronous and active-high; all state is
//   updated only on posedge clk.
//  Reset values: state=IDLE, ready=1, start=0.
//   data = (CHARS-2) x 8'h20, then 8'h0A, 8'h0D.
//  FSM: IDLE -> ABS -> CONV -> PACK -> SEND -> WAIT -> IDLE.
//   IDLE: ready=1. On value_valid, latch value; ready falls next cycle.
//   ABS (1 cycle): neg = value[VALUE_W-1]. mag = neg ? -value : value, as VALUE_W-bit unsigned.
//    Most-negative value: mag = 2^(VALUE_W-1), which is representable.
//   CONV (VALUE_W cycles): iterative double-dabble in calc_bin2bcd.
//    Each cycle: add 3 to every BCD nibble >= 5, then shift one bit in from mag MSB.
//   PACK (DIGITS cycles): scan BCD from most significant digit, one digit per cycle.
//    Leading zeros become 8'h20. The least significant digit is always printed ("0" for 0).
//    If neg, 8'h2D ('-') goes immediately left of the first printed digit.
//    Field = bytes 0..CHARS-3, right-justified; bytes CHARS-2 and CHARS-1 = 8'h0A, 8'h0D.
//    All unused leading bytes = 8'h20. data updates only at PACK exit.
//   SEND: start=1, held until tx_idle observed low (ack), then -> WAIT with start=0.
//   WAIT: stay until tx_idle high, then -> IDLE, ready=1.
//  Latency: start first high exactly 2+VALUE_W+DIGITS cycles after the accept edge
//   (44 at defaults). data is stable from that cycle until IDLE is re-entered.
//  value_valid while ready=0: ignored, nothing queued; the producer must hold or retry.
//  tx_idle already low on SEND entry (serializer still busy): treated as ack.
//   Go to WAIT; no start pulse is lost because start was asserted >= 1 cycle.
//  Reset mid-operation, any state: next cycle all outputs take reset values.
//   The conversion in progress is discarded.
//  Simultaneous reset and value_valid: reset wins; the value is not accepted.
// STRUCTURE
//  Shared package calc_pkg:
//   ASCII constants CH_SPACE=8'h20, CH_MINUS=8'h2D, CH_ZERO=8'h30, CH_LF=8'h0A, CH_CR=8'h0D.
//   FSM state localparams (3-bit).
//   Function calc_digits(width) returning DIGITS.
//  Sub-module calc_bin2bcd(VALUE_W, DIGITS): load/step/done interface;
//   one shift-add-3 iteration per cycle; bcd output DIGITS*4 bits.
//  Top holds the FSM, sign handling, PACK shifter and handshake, about 200 lines total.
// TESTING
//  1 reset, then idle -> ready=1, start=0; data = 14 spaces,0A,0D; no start for 100 cycles.
//  2 value=32'd0 -> start at cycle 44; data = 13 spaces,"0",0A,0D.
//    Model tx_idle low 5 cycles after start; ready returns the cycle after tx_idle rises.
//  3 value=-42 -> data = 11 spaces,"-42",0A,0D.
//    value=2147483647 -> data = 4 spaces,"2147483647",0A,0D.
//  4 value=32'h80000000 -> data = 3 spaces,"-2147483648",0A,0D.
//    value_valid pulsed during CONV -> ignored; exactly one message.
//  5 reset asserted mid-CONV, then value=7 -> start at cycle 44 after the new accept;
//    data = 13 spaces,"7",0A,0D.
//  6 tx_idle held low before SEND -> start high exactly 1 cycle, then WAIT;
//    release tx_idle -> IDLE, ready=1.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator result path: ASCII codes, formatter
// FSM states and the decimal digit-count helper.
package calc_pkg;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ABS  = 3'd1,
      ST_CONV = 3'd2,
      ST_PACK = 3'd3,
      ST_SEND = 3'd4,
      ST_WAIT = 3'd5
   } calc_state_e;

   // ceil(width * log10(2)), with log10(2) approximated as 0.30103
   function automatic int calc_digits(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Iterative double-dabble converter: load captures the binary value, then one
// add-3/shift iteration runs per cycle; done rises after the last iteration.
module calc_bin2bcd
   import calc_pkg::*;
#(
   parameter int VALUE_W = 32,
   parameter int DIGITS  = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [VALUE_W-1:0]    bin,
   output logic [DIGITS*4-1:0]   bcd,
   output logic                  done
);

   localparam int BW = DIGITS * 4;
   localparam int CW = $clog2(VALUE_W + 1);

   logic [VALUE_W-1:0] bin_q, bin_d;
   logic [BW-1:0]      bcd_q, bcd_d;
   logic [BW-1:0]      adj;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               done_q, done_d;

   always_comb begin
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      done_d = done_q;
      adj    = bcd_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end
      end
      if (load) begin
         bin_d  = bin;
         bcd_d  = '0;
         cnt_d  = CW'(VALUE_W);
         done_d = 1'b0;
      end else if (cnt_q != '0) begin
         // the top adjusted bit is always zero for in-range inputs and is dropped
         bcd_d  = BW'({adj, bin_q[VALUE_W-1]});
         bin_d  = {bin_q[VALUE_W-2:0], 1'b0};
         cnt_d  = cnt_q - 1'b1;
         done_d = (cnt_q == CW'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign bcd  = bcd_q;
   assign done = done_q;

endmodule

// File: rtl/calc_result_formatter.sv
// Converts a signed result to a right-justified decimal ASCII message ending
// in LF,CR and hands it to the byte serializer via start/tx_idle.
module calc_result_formatter
   import calc_pkg::*;
#(
   parameter int DATASIZE = 128,
   parameter int VALUE_W  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [VALUE_W-1:0]  value,
   input  logic                value_valid,
   output logic                ready,
   output logic [DATASIZE-1:0] data,
   output logic                start,
   input  logic                tx_idle
);

   localparam int CHARS  = DATASIZE / 8;
   localparam int DIGITS = calc_digits(VALUE_W);
   localparam int FW     = (CHARS - 2) * 8;
   localparam int BW     = DIGITS * 4;
   localparam int PCW    = $clog2(DIGITS + 1);
   localparam logic [DATASIZE-1:0] DATA_RST = {{(CHARS-2){CH_SPACE}}, CH_LF, CH_CR};

   if (CHARS < DIGITS + 3) begin : g_size_check
      $error("calc_result_formatter: DATASIZE too small for VALUE_W digits plus sign, LF, CR");
   end

   calc_state_e         state_q, state_d;
   logic [VALUE_W-1:0]  value_q, value_d;
   logic                neg_q, neg_d;
   logic [BW-1:0]       pack_bcd_q, pack_bcd_d;
   logic [PCW-1:0]      pack_cnt_q, pack_cnt_d;
   logic                started_q, started_d;
   logic [FW-1:0]       field_q, field_d;
   logic [DATASIZE-1:0] data_q, data_d;

   logic [VALUE_W-1:0]  mag;
   logic                bcd_load;
   logic [BW-1:0]       bcd;
   logic                bcd_done;
   logic [3:0]          digit;
   logic                last_digit;
   logic                print;
   logic [7:0]          ch;

   // most-negative input negates to 2^(VALUE_W-1), still exact as unsigned
   assign mag = value_q[VALUE_W-1] ? (~value_q + 1'b1) : value_q;

   calc_bin2bcd #(
      .VALUE_W (VALUE_W),
      .DIGITS  (DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .load  (bcd_load),
      .bin   (mag),
      .bcd   (bcd),
      .done  (bcd_done)
   );

   always_comb begin
      state_d    = state_q;
      value_d    = value_q;
      neg_d      = neg_q;
      pack_bcd_d = pack_bcd_q;
      pack_cnt_d = pack_cnt_q;
      started_d  = started_q;
      field_d    = field_q;
      data_d     = data_q;
      bcd_load   = 1'b0;
      ready      = 1'b0;
      start      = 1'b0;
      digit      = pack_bcd_q[BW-1 -: 4];
      last_digit = (pack_cnt_q == PCW'(DIGITS - 1));
      print      = started_q | (digit != 4'd0) | last_digit;
      ch         = print ? (CH_ZERO + {4'h0, digit}) : CH_SPACE;

      case (state_q)
         ST_IDLE: begin
            ready = 1'b1;
            if (value_valid) begin
               value_d = value;
               state_d = ST_ABS;
            end
         end
         ST_ABS: begin
            neg_d    = value_q[VALUE_W-1];
            bcd_load = 1'b1;
            state_d  = ST_CONV;
         end
         ST_CONV: begin
            if (bcd_done) begin
               pack_bcd_d = bcd;
               pack_cnt_d = '0;
               started_d  = 1'b0;
               field_d    = {(CHARS-2){CH_SPACE}};
               state_d    = ST_PACK;
            end
         end
         ST_PACK: begin
            // shift characters in from the right; the byte just left of the
            // first printed digit is still a space and becomes the sign
            field_d = FW'({field_q, ch});
            if (print && !started_q && neg_q) begin
               field_d[15:8] = CH_MINUS;
            end
            started_d  = print;
            pack_bcd_d = {pack_bcd_q[BW-5:0], 4'h0};
            pack_cnt_d = pack_cnt_q + 1'b1;
            if (last_digit) begin
               data_d  = {field_d, CH_LF, CH_CR};
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            start = 1'b1;
            if (!tx_idle) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (tx_idle) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         value_q    <= '0;
         neg_q      <= 1'b0;
         pack_bcd_q <= '0;
         pack_cnt_q <= '0;
         started_q  <= 1'b0;
         field_q    <= '0;
         data_q     <= DATA_RST;
      end else begin
         state_q    <= state_d;
         value_q    <= value_d;
         neg_q      <= neg_d;
         pack_bcd_q <= pack_bcd_d;
         pack_cnt_q <= pack_cnt_d;
         started_q  <= started_d;
         field_q    <= field_d;
         data_q     <= data_d;
      end
   end

   assign data = data_q;

endmodule
